// File: rtl/aes_dec_pkg.sv
// Shared types, InvSbox contents and GF(2^8) helpers for the iterative AES inverse cipher.
package aes_dec_pkg;

   typedef logic [127:0] aes_block_t;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ARK  = 3'd1,
      ST_ISR  = 3'd2,
      ST_ISB0 = 3'd3,
      ST_ISB1 = 3'd4,
      ST_IMC  = 3'd5,
      ST_DONE = 3'd6
   } fsm_state_e;

   function automatic int nr_of(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

   // Row-major InvSbox; entry 0x00 sits in the top byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      return INV_SBOX[8*(255-int'(a)) +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul9(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul11(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul13(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gf_mul14(input logic [7:0] b);
      return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
              gf_mul9(a0)  ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
              gf_mul13(a0) ^ gf_mul9(a1)  ^ gf_mul14(a2) ^ gf_mul11(a3),
              gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2)  ^ gf_mul14(a3)};
   endfunction

endpackage

// File: rtl/aes_inv_mix_slice.sv
// InvMixColumns on COLS_PER_CYCLE consecutive columns starting at col_i; other columns pass through.
module aes_inv_mix_slice
   import aes_dec_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  aes_block_t state_i,
   input  logic [1:0] col_i,
   output aes_block_t state_o
);

   logic [31:0] col_in  [4];
   logic [31:0] col_out [4];
   logic [31:0] mix_in  [COLS_PER_CYCLE];

   always_comb begin
      for (int c = 0; c < 4; c++) col_in[c] = state_i[127-32*c -: 32];
   end

   // Only the selected slice goes through the mixing logic; the pointer wraps mod 4.
   always_comb begin
      col_out = col_in;
      for (int j = 0; j < COLS_PER_CYCLE; j++) begin
         mix_in[j] = col_in[col_i + 2'(j)];
         col_out[col_i + 2'(j)] = inv_mix_col(mix_in[j]);
      end
   end

   always_comb begin
      state_o = '0;
      for (int c = 0; c < 4; c++) state_o[127-32*c -: 32] = col_out[c];
   end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128/192/256 inverse cipher with valid/ready on both sides.
// AES_INV_STEP_EN adds AES_DEBUG/AES_STEP for single-stepping the round FSM.
module aes_inv_cipher_iter
   import aes_dec_pkg::*;
#(
   parameter int KEY_BITS       = 128,
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                               CLK,
   input  logic                               RESET_N,
   input  logic                               IN_VALID,
   output logic                               IN_READY,
   input  logic [127:0]                       IN_MSG,
   input  logic [(nr_of(KEY_BITS)+1)*128-1:0] KEY_SCHED,
   output logic                               OUT_VALID,
   input  logic                               OUT_READY,
   output logic [127:0]                       OUT_MSG,
   output logic                               BUSY,
   output logic [3:0]                         ROUND
`ifdef AES_INV_STEP_EN
   ,
   input  logic                               AES_DEBUG,
   input  logic                               AES_STEP
`endif
);

   localparam int NR = nr_of(KEY_BITS);

   if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256)) begin : g_bad_key
      $error("aes_inv_cipher_iter: KEY_BITS must be 128, 192 or 256");
   end
   if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("aes_inv_cipher_iter: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   fsm_state_e  fsm_q, fsm_d;
   aes_block_t  state_q, state_d;
   logic [3:0]  round_q, round_d;
   logic [1:0]  col_q, col_d;
   logic [7:0]  rom_q [16];
   logic [7:0]  rom_d [16];
   aes_block_t  rk, isr_blk, isb_blk, imc_blk;
   logic        adv;

`ifdef AES_INV_STEP_EN
   logic step_q, step_d;
   assign step_d = AES_STEP;
   assign adv    = ~AES_DEBUG | (AES_STEP & ~step_q);
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) step_q <= 1'b0;
      else          step_q <= step_d;
   end
`else
   assign adv = 1'b1;
`endif

   assign rk = KEY_SCHED[128*round_q +: 128];

   // Byte (row r, column c) lives at index 4c+r; row r rotates right by r.
   always_comb begin
      isr_blk = '0;
      isb_blk = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            isr_blk[127-8*(4*c+r) -: 8] = state_q[127-8*(4*((c-r+4)%4)+r) -: 8];
      for (int i = 0; i < 16; i++) begin
         rom_d[i] = inv_sbox(state_q[127-8*i -: 8]);
         isb_blk[127-8*i -: 8] = rom_q[i];
      end
   end

   aes_inv_mix_slice #(.COLS_PER_CYCLE(COLS_PER_CYCLE)) u_mix (
      .state_i (state_q),
      .col_i   (col_q),
      .state_o (imc_blk)
   );

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      col_d   = col_q;
      case (fsm_q)
         ST_IDLE: if (IN_VALID) begin
            state_d = IN_MSG;
            round_d = 4'(NR);
            fsm_d   = ST_ARK;
         end
         ST_ARK: if (adv) begin
            state_d = state_q ^ rk;
            // Holds at 0 after the final key so ROUND stays within NR..0.
            round_d = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
            col_d   = 2'd0;
            if (round_q == 4'd0)          fsm_d = ST_DONE;
            else if (round_q == 4'(NR))   fsm_d = ST_ISR;
            else                          fsm_d = ST_IMC;
         end
         ST_ISR: if (adv) begin
            state_d = isr_blk;
            fsm_d   = ST_ISB0;
         end
         ST_ISB0: fsm_d = ST_ISB1;
         ST_ISB1: if (adv) begin
            state_d = isb_blk;
            fsm_d   = ST_ARK;
         end
         ST_IMC: if (adv) begin
            state_d = imc_blk;
            if (col_q == 2'(4 - COLS_PER_CYCLE)) begin
               col_d = 2'd0;
               fsm_d = ST_ISR;
            end else begin
               col_d = col_q + 2'(COLS_PER_CYCLE);
            end
         end
         ST_DONE: if (OUT_READY) fsm_d = ST_IDLE;
         default: fsm_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         fsm_q   <= ST_IDLE;
         state_q <= '0;
         round_q <= 4'(NR);
         col_q   <= 2'd0;
         for (int i = 0; i < 16; i++) rom_q[i] <= 8'h00;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
         col_q   <= col_d;
         for (int i = 0; i < 16; i++) rom_q[i] <= rom_d[i];
      end
   end

   assign IN_READY  = (fsm_q == ST_IDLE);
   assign OUT_VALID = (fsm_q == ST_DONE);
   assign BUSY      = (fsm_q != ST_IDLE);
   assign OUT_MSG   = state_q;
   assign ROUND     = round_q;

endmodule
